// File: rtl/action_selector.sv
// action_selector: four-state lane selector (greedy argmax with minimum-hold) and handshake output.
// Define ACTION_SEL_EXPLORE_EN to build the LFSR epsilon-exploration branch.
module action_selector #(
  parameter int         MIN_GREEN  = 2,
  parameter logic [7:0] EPS_THRESH = 8'd26,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learning,
  input  logic              s_valid,
  input  logic [11:0]       S,
  output logic              s_ready,
  output logic [1:0]        A,
  output logic              a_valid,
  input  logic              a_ready,
  output logic signed [5:0] R,
  output logic              explored
);

  typedef enum logic [1:0] {IDLE, DECODE, SELECT, ISSUE} state_t;

  localparam logic [2:0] MIN_G = 3'(MIN_GREEN);

  state_t      state, state_nxt;
  logic [11:0] s_p0;
  logic [1:0]  argmax_p1;
  logic [2:0]  hold_cnt;
  logic        issued;
  logic [1:0]  last_a;
  logic [1:0]  sel_a;
  logic        sel_explored;
  logic        handshake;

  // Lowest index wins on ties, so all-zero levels pick lane 0.
  function automatic logic [1:0] argmax4(input logic [11:0] s);
    logic [2:0] best;
    logic [1:0] idx;
    best = s[2:0];
    idx  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (s[3*i +: 3] > best) begin
        best = s[3*i +: 3];
        idx  = 2'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic signed [5:0] neg_sum(input logic [11:0] s);
    logic [5:0] sum;
    sum = 6'(s[2:0]) + 6'(s[5:3]) + 6'(s[8:6]) + 6'(s[11:9]);
    return -$signed(sum);
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] h);
    return (h == 3'd7) ? 3'd7 : h + 3'd1;
  endfunction

  assign a_valid   = (state == ISSUE);
  assign handshake = a_valid && a_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid && s_ready) state_nxt = DECODE;
      DECODE:  state_nxt = SELECT;
      SELECT:  state_nxt = ISSUE;
      ISSUE:   if (a_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ACTION_SEL_EXPLORE_EN
  logic [7:0] lfsr;

  // Fibonacci taps 8,6,5,4; free-running regardless of FSM state.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_next(lfsr);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{learning, EPS_THRESH, LFSR_SEED};
`endif

  always_comb begin
    sel_a        = argmax_p1;
    sel_explored = 1'b0;
    if (issued && (hold_cnt < MIN_G)) sel_a = last_a;
`ifdef ACTION_SEL_EXPLORE_EN
    else if (learning && (lfsr < EPS_THRESH)) begin
      sel_a        = lfsr[1:0];
      sel_explored = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      A        <= 2'd0;
      explored <= 1'b0;
      R        <= '0;
      hold_cnt <= 3'd0;
      issued   <= 1'b0;
      last_a   <= 2'd0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == IDLE);
      if (state == DECODE) R <= neg_sum(s_p0);
      if (state == SELECT) begin
        A        <= sel_a;
        explored <= sel_explored;
      end
      if (handshake) begin
        issued   <= 1'b1;
        last_a   <= A;
        hold_cnt <= (!issued || (A != last_a)) ? 3'd1 : sat_inc(hold_cnt);
      end
    end
  end

  // Stage p0: capture state on acceptance; stage p1: argmax during DECODE.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && s_valid && s_ready) s_p0 <= S;
    if (state == DECODE) argmax_p1 <= argmax4(s_p0);
  end

endmodule

// File: tb/tb_action_selector.sv
// Bench for action_selector: transaction-level reference model plus directed literal checks.
module tb_action_selector;

  localparam logic [7:0] SEED = 8'hA5;

  logic              clk;
  logic              rst;
  logic              learning_v [2];
  logic              s_valid_v  [2];
  logic [11:0]       s_v        [2];
  logic              s_ready_v  [2];
  logic [1:0]        a_v        [2];
  logic              a_valid_v  [2];
  logic              a_ready_v  [2];
  logic signed [5:0] r_v        [2];
  logic              explored_v [2];

  action_selector dut0 (
    .clk(clk), .rst(rst), .learning(learning_v[0]), .s_valid(s_valid_v[0]), .S(s_v[0]),
    .s_ready(s_ready_v[0]), .A(a_v[0]), .a_valid(a_valid_v[0]), .a_ready(a_ready_v[0]),
    .R(r_v[0]), .explored(explored_v[0])
  );

  action_selector #(.MIN_GREEN(1), .EPS_THRESH(8'd255)) dut1 (
    .clk(clk), .rst(rst), .learning(learning_v[1]), .s_valid(s_valid_v[1]), .S(s_v[1]),
    .s_ready(s_ready_v[1]), .A(a_v[1]), .a_valid(a_valid_v[1]), .a_ready(a_ready_v[1]),
    .R(r_v[1]), .explored(explored_v[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit done   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: per-DUT transaction state, keyed by clock count since reset.
  int  mg  [2] = '{2, 1};
  int  eps [2] = '{26, 255};
  bit  m_busy [2], m_ready [2], m_issued [2];
  int  m_hold [2], m_last [2], m_issue_at [2];
  int  m_exp_a [2], m_exp_x [2], m_exp_r [2];
  logic [11:0] m_s [2];
  int  cyc, cyc_pre;

`ifdef ACTION_SEL_EXPLORE_EN
  localparam bit EXPLORE_EN = 1'b1;
`else
  localparam bit EXPLORE_EN = 1'b0;
`endif

  function automatic int lvl(input logic [11:0] s, input int i);
    return int'(s[3*i +: 3]);
  endfunction

  function automatic int greedy(input logic [11:0] s);
    int best = 0;
    for (int i = 1; i < 4; i++) if (lvl(s, i) > lvl(s, best)) best = i;
    return best;
  endfunction

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] x = SEED;
    repeat (n) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    return x;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_ready[d] = 0; m_issued[d] = 0;
        m_hold[d] = 0; m_last[d] = 0; m_issue_at[d] = 0;
      end
    end else begin
      cyc_pre = cyc;
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          if (s_valid_v[d] && m_ready[d]) begin
            m_busy[d]     = 1;
            m_ready[d]    = 0;
            m_s[d]        = s_v[d];
            m_issue_at[d] = cyc + 2;
            m_exp_r[d]    = -(lvl(s_v[d], 0) + lvl(s_v[d], 1) + lvl(s_v[d], 2) + lvl(s_v[d], 3));
          end else begin
            m_ready[d] = 1;
          end
        end else if (cyc_pre >= m_issue_at[d] && a_ready_v[d]) begin
          if (!m_issued[d] || m_exp_a[d] != m_last[d]) m_hold[d] = 1;
          else if (m_hold[d] < 7) m_hold[d] = m_hold[d] + 1;
          m_last[d]   = m_exp_a[d];
          m_issued[d] = 1;
          m_busy[d]   = 0;
          m_ready[d]  = 1;
        end else if (cyc == m_issue_at[d]) begin
          logic [7:0] lf;
          lf = lfsr_at(m_issue_at[d] - 1);
          if (m_issued[d] && m_hold[d] < mg[d]) begin
            m_exp_a[d] = m_last[d]; m_exp_x[d] = 0;
          end else if (EXPLORE_EN && learning_v[d] && int'(lf) < eps[d]) begin
            m_exp_a[d] = int'(lf[1:0]); m_exp_x[d] = 1;
          end else begin
            m_exp_a[d] = greedy(m_s[d]); m_exp_x[d] = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst && !done) begin
      for (int d = 0; d < 2; d++) begin
        bit exp_av;
        exp_av = m_busy[d] && (cyc >= m_issue_at[d]);
        check($sformatf("s_ready[%0d]", d), int'(s_ready_v[d]), int'(m_ready[d]));
        check($sformatf("a_valid[%0d]", d), int'(a_valid_v[d]), int'(exp_av));
        if (exp_av) begin
          check($sformatf("A[%0d]", d), int'(a_v[d]), m_exp_a[d]);
          check($sformatf("explored[%0d]", d), int'(explored_v[d]), m_exp_x[d]);
          check($sformatf("R[%0d]", d), int'(r_v[d]), m_exp_r[d]);
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    int k = 0;
    while (!s_ready_v[d] && k < 20) begin @(negedge clk); k++; end
    if (!s_ready_v[d]) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!a_valid_v[d] && lat < 10) begin @(negedge clk); lat++; end
    if (!a_valid_v[d]) check("valid_timeout", 0, 1);
  endtask

  task automatic transact(input int d, input logic [11:0] s, input int hold,
                          output logic [1:0] a, output logic signed [5:0] r,
                          output logic x, output int lat);
    wait_ready(d);
    s_v[d] = s;
    s_valid_v[d] = 1'b1;
    @(negedge clk);
    s_valid_v[d] = 1'b0;
    s_v[d] = 12'($urandom);
    a_ready_v[d] = (hold == 0);
    wait_valid(d, lat);
    a = a_v[d]; r = r_v[d]; x = explored_v[d];
    for (int k = 0; k < hold; k++) begin
      s_valid_v[d] = (k % 2 == 0);
      s_v[d] = 12'($urandom);
      @(negedge clk);
    end
    s_valid_v[d] = 1'b0;
    a_ready_v[d] = 1'b1;
    @(negedge clk);
    a_ready_v[d] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  logic [11:0] xtbl [8] = '{12'h1C8, 12'h249, 12'h038, 12'hE00, 12'h000, 12'hFFF, 12'h123, 12'hABC};

  initial begin
    logic [1:0]        ga;
    logic signed [5:0] gr;
    logic              gx;
    int                gl;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      learning_v[d] = 1'b0; s_valid_v[d] = 1'b0; s_v[d] = 12'h000; a_ready_v[d] = 1'b0;
    end
    #1 rst = 1'b0;
    #3;
    check("rst_a_valid", int'(a_valid_v[0]), 0);
    check("rst_s_ready", int'(s_ready_v[0]), 0);
    check("rst_A", int'(a_v[0]), 0);
    check("rst_R", int'(r_v[0]), 0);
    check("rst_explored", int'(explored_v[0]), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Greedy pick with latency
    transact(0, 12'h1C8, 0, ga, gr, gx, gl);
    check("greedy_A", int'(ga), 2);
    check("greedy_R", int'(gr), -8);
    check("greedy_explored", int'(gx), 0);
    check("greedy_latency", gl, 2);

    // Tie break and minimum hold
    do_reset();
    transact(0, 12'h249, 0, ga, gr, gx, gl);
    check("tie_A", int'(ga), 0);
    check("tie_R", int'(gr), -4);
    transact(0, 12'h038, 0, ga, gr, gx, gl);
    check("hold_A", int'(ga), 0);
    transact(0, 12'h038, 0, ga, gr, gx, gl);
    check("release_A", int'(ga), 1);

    // Backpressure with ignored s_valid pulses
    transact(0, 12'h038, 5, ga, gr, gx, gl);
    check("bp_A", int'(ga), 1);
    check("bp_R", int'(gr), -7);

    // Reset while issuing
    wait_ready(0);
    s_v[0] = 12'h1C8;
    s_valid_v[0] = 1'b1;
    @(negedge clk);
    s_valid_v[0] = 1'b0;
    wait_valid(0, gl);
    #2 rst = 1'b0;
    #1;
    check("midrst_a_valid", int'(a_valid_v[0]), 0);
    check("midrst_s_ready", int'(s_ready_v[0]), 0);
    check("midrst_A", int'(a_v[0]), 0);
    check("midrst_R", int'(r_v[0]), 0);
    check("midrst_explored", int'(explored_v[0]), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    transact(0, 12'hE00, 0, ga, gr, gx, gl);
    check("post_rst_A", int'(ga), 3);
    check("post_rst_R", int'(gr), -7);

    // Exploration instance and learning on the default instance
    learning_v[1] = 1'b1;
    for (int i = 0; i < 8; i++) transact(1, xtbl[i], i % 3, ga, gr, gx, gl);
    learning_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) transact(0, xtbl[7 - i], 0, ga, gr, gx, gl);
    learning_v[0] = 1'b0;

    repeat (2) @(negedge clk);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
